asin_angle_search: RTL and testbench

//  Inverse of the sine lookup. Takes an IEEE-754 single-precision sine value in [0.0, 1.0].

---
 rtl/asin_angle_search_if.sv | 15 +
 rtl/asin_angle_search.sv | 171 +++++++++++++++++
 tb/tb_asin_angle_search.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/asin_angle_search_if.sv
// Request/result bundle for the arcsine angle search: one request in, one angle result out.
interface asin_angle_search_if #(
    parameter int unsigned ANGLE_W = 7
);
    logic               start;
    logic [31:0]        value;
    logic               busy;
    logic               done;
    logic [ANGLE_W-1:0] angle;
    logic               exact;
    logic               err;

    modport master (output start, value, input busy, done, angle, exact, err);
    modport slave  (input start, value, output busy, done, angle, exact, err);
endinterface

// File: rtl/asin_angle_search.sv
// Floor arcsine in whole degrees: a 7-step successive-approximation search over a
// float32 sine table that is built at elaboration from integer fixed-point math.
module asin_angle_search #(
    parameter int unsigned ANGLE_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    asin_angle_search_if.slave bus
);

    localparam int unsigned FRAC    = 60;
    localparam int unsigned ROM_N   = 128;
    localparam int unsigned MAX_DEG = 90;

    typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

    // atan(1/n) scaled by 2^FRAC, alternating series
    function automatic logic [127:0] atan_inv(input int unsigned n);
        logic [127:0] pw;
        logic [127:0] sum;
        pw  = (128'(1) << FRAC) / 128'(n);
        sum = pw;
        for (int unsigned i = 1; i < 32; i++) begin
            pw = pw / 128'(n * n);
            if (i[0]) sum = sum - pw / 128'(2 * i + 1);
            else      sum = sum + pw / 128'(2 * i + 1);
        end
        return sum;
    endfunction

    // sin(k deg) via Machin pi and Taylor series, rounded to nearest-even float32
    function automatic logic [31:0] sin_f32(input int k);
        logic [127:0] pi_fx;
        logic [127:0] x;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] full;
        logic [127:0] rem;
        logic [127:0] half;
        int           p;
        int           e;
        int           sh;
        if (k == 0) return 32'h0000_0000;
        pi_fx = (atan_inv(5) << 4) - (atan_inv(239) << 2);
        x     = pi_fx * 128'(k) / 128'(180);
        term  = x;
        sum   = x;
        for (int unsigned i = 1; i <= 20; i++) begin
            term = (((term * x) >> FRAC) * x) >> FRAC;
            term = term / 128'((2 * i) * (2 * i + 1));
            if (i[0]) sum = sum - term;
            else      sum = sum + term;
        end
        p = 0;
        for (int i = 0; i < 128; i++) if (sum[i]) p = i;
        sh   = p - 23;
        full = sum >> sh;
        rem  = sum & ((128'(1) << sh) - 128'(1));
        half = 128'(1) << (sh - 1);
        if (rem > half || (rem == half && full[0])) full = full + 128'(1);
        if (full[24]) begin
            full = full >> 1;
            p    = p + 1;
        end
        e = p - int'(FRAC) + 127;
        return {1'b0, 8'(e), full[22:0]};
    endfunction

    // Padding entries above 90 deg are never selected; the candidate range check guards them
    logic [31:0] rom [ROM_N];
    for (genvar k = 0; k < ROM_N; k++) begin : g_rom
        if (k <= MAX_DEG) begin : g_val
            localparam logic [31:0] ENTRY = sin_f32(k);
            assign rom[k] = ENTRY;
        end else begin : g_pad
            assign rom[k] = 32'hFFFF_FFFF;
        end
    end

    state_t             state_q, state_d;
    logic [6:0]         acc_q, acc_d;
    logic [2:0]         b_q, b_d;
    logic [31:0]        v_q, v_d;
    logic               errp_q, errp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               exact_q, exact_d;
    logic               err_q, err_d;

    logic               in_err_c;
    logic [6:0]         cand_c;

    // Negative values other than -0.0, Inf/NaN, and anything above 1.0 are out of domain
    assign in_err_c = (bus.value[31] && bus.value != 32'h8000_0000)
                   || (bus.value[30:23] == 8'hFF)
                   || (!bus.value[31] && bus.value > 32'h3F80_0000);
    assign cand_c   = acc_q | (7'(1) << b_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        v_d     = v_q;
        errp_d  = errp_q;
        done_d  = 1'b0;
        angle_d = angle_q;
        exact_d = exact_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !done_q) begin
                    acc_d   = 7'd0;
                    state_d = in_err_c ? FINISH : SEARCH;
                    errp_d  = in_err_c;
                    if (!in_err_c) begin
                        v_d = bus.value[31] ? 32'h0000_0000 : bus.value;
                        b_d = 3'd6;
                    end
                end
            end
            SEARCH: begin
                if (cand_c <= 7'(MAX_DEG) && rom[cand_c] <= v_q) acc_d = cand_c;
                if (b_q == 3'd0) state_d = FINISH;
                else             b_d     = b_q - 3'd1;
            end
            FINISH: begin
                done_d  = 1'b1;
                angle_d = errp_q ? '0 : ANGLE_W'(acc_q);
                exact_d = !errp_q && (rom[acc_q] == v_q);
                err_d   = errp_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            v_q     <= '0;
            errp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            angle_q <= '0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            v_q     <= v_d;
            errp_q  <= errp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            angle_q <= angle_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.angle = angle_q;
    assign bus.exact = exact_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_asin_angle_search.sv
// Bench for asin_angle_search: vector table, hand-written corner sequences and a ROM sweep.
module tb_asin_angle_search;

    logic clk = 1'b0;
    logic rst_n;

    asin_angle_search_if #(.ANGLE_W(7)) bus ();

    asin_angle_search #(.ANGLE_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] angle;
        logic       exact;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic [6:0]  angle;
        logic        exact;
        logic        err;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mrom [91];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Double-precision sine rounded to nearest-even float32
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] b;
        logic [52:0] m;
        logic [28:0] rem;
        logic [24:0] f;
        int          e;
        if (r == 0.0) return 32'h0;
        b   = $realtobits(r);
        m   = {1'b1, b[51:0]};
        rem = m[28:0];
        f   = {1'b0, m[52:29]};
        e   = int'(b[62:52]) - 1023 + 127;
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && f[0])) f = f + 25'd1;
        if (f[24]) begin
            f = f >> 1;
            e = e + 1;
        end
        return {1'b0, 8'(e), f[22:0]};
    endfunction

    task automatic wait_done(input string name);
        int   n;
        exp_t ex;
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        ex = sb.pop_front();
        if (!bus.done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: no done after %0d cycles", name, n);
        end else begin
            check({name, " angle"}, 32'(bus.angle), 32'(ex.angle));
            check({name, " exact"}, 32'(bus.exact), 32'(ex.exact));
            check({name, " err"},   32'(bus.err),   32'(ex.err));
            check({name, " lat"},   32'(n),         32'(ex.lat));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input string name, input logic [31:0] val, input logic [6:0] ea,
                           input logic ex, input logic ee, input int el);
        sb.push_back('{angle: ea, exact: ex, err: ee, lat: el});
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = val;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = $urandom();
        wait_done(name);
    endtask

    vec_t vecs[12];
    int   dones;

    initial begin
        for (int k = 0; k <= 90; k++) mrom[k] = to_f32($sin(real'(k) * 3.14159265358979323846 / 180.0));

        vecs[0]  = '{32'h3F00_0000, 7'd30, 1'b1, 1'b0, 8};
        vecs[1]  = '{32'h3F40_0000, 7'd48, 1'b0, 1'b0, 8};
        vecs[2]  = '{32'h3F80_0000, 7'd90, 1'b1, 1'b0, 8};
        vecs[3]  = '{32'h0000_0000, 7'd0,  1'b1, 1'b0, 8};
        vecs[4]  = '{32'h8000_0000, 7'd0,  1'b1, 1'b0, 8};
        vecs[5]  = '{32'h0000_0001, 7'd0,  1'b0, 1'b0, 8};
        vecs[6]  = '{32'h3F80_0001, 7'd0,  1'b0, 1'b1, 1};
        vecs[7]  = '{32'hBF00_0000, 7'd0,  1'b0, 1'b1, 1};
        vecs[8]  = '{32'h7FC0_0000, 7'd0,  1'b0, 1'b1, 1};
        vecs[9]  = '{32'h7F80_0000, 7'd0,  1'b0, 1'b1, 1};
        vecs[10] = '{32'h3F7F_FFFF, 7'd89, 1'b0, 1'b0, 8};
        vecs[11] = '{32'h3F35_04F3, 7'd45, 1'b1, 1'b0, 8};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.value = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",  32'(bus.busy),  32'd0);
        check("reset done",  32'(bus.done),  32'd0);
        check("reset angle", 32'(bus.angle), 32'd0);
        check("reset exact", 32'(bus.exact), 32'd0);
        check("reset err",   32'(bus.err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_req($sformatf("vec%0d", i), vecs[i].value, vecs[i].angle, vecs[i].exact,
                    vecs[i].err, vecs[i].lat);

        // start held high through a busy request with a different value
        sb.push_back('{angle: 7'd30, exact: 1'b1, err: 1'b0, lat: 8});
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'h3F00_0000;
        @(posedge clk);
        #1;
        bus.value = 32'h3F80_0000;
        wait_done("held_start");
        check("held_start busy after done", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("held_start no second done", 32'(bus.done), 32'd0);
        check("held_start angle held", 32'(bus.angle), 32'd30);
        run_req("after_held", 32'h3F80_0000, 7'd90, 1'b1, 1'b0, 8);

        // reset in the middle of a search
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 32'h3F00_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy",  32'(bus.busy),  32'd0);
        check("midrst done",  32'(bus.done),  32'd0);
        check("midrst angle", 32'(bus.angle), 32'd0);
        check("midrst exact", 32'(bus.exact), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("midrst no done", 32'(dones), 32'd0);
        run_req("post_rst", 32'h3F35_04F3, 7'd45, 1'b1, 1'b0, 8);

        for (int k = 0; k <= 90; k++) begin
            run_req($sformatf("sweep%0d", k), mrom[k], 7'(k), 1'b1, 1'b0, 8);
            if (k < 90)
                run_req($sformatf("sweep%0d+ulp", k), mrom[k] + 32'd1, 7'(k), 1'b0, 1'b0, 8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
